addsub_unit: RTL and testbench

//  Parametrised, chunk-serial signed/unsigned add/subtract unit with valid/ready handshakes.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_unit_chunk_add.sv | 22 ++
 rtl/addsub_unit.sv | 124 ++++++++++++
 tb/tb_addsub_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the chunk-serial add/subtract unit.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/addsub_unit_chunk_add.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its top bit
// so the parent can derive signed overflow on the final slice.
module chunk_add #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] s;

  assign s     = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = s[CHUNK-1:0];
  assign cout  = s[CHUNK];
  // Carry into the top bit falls out of the top-bit sum equation.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/addsub_unit.sv
// Chunk-serial add/subtract with valid/ready handshakes and carry/overflow/zero flags.
// Optional macro SATURATE_EN clamps the result on signed overflow.
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e           state, state_n;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             c_q;
  logic [CW-1:0]    cnt;
  logic             carry_q, ovf_q, zero_q;

  logic [CHUNK-1:0] ca, cb, csum;
  logic             cout, cmsb, last, ovf_n;
  logic [WIDTH-1:0] res_n, res_fin;

  assign ca    = a_q[cnt*CHUNK +: CHUNK];
  assign cb    = b_q[cnt*CHUNK +: CHUNK];
  assign last  = (cnt == CW'(NCHUNK - 1));
  assign ovf_n = cout ^ cmsb;

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .a    (ca),
    .b    (cb),
    .cin  (c_q),
    .sum  (csum),
    .cout (cout),
    .c_msb(cmsb)
  );

  always_comb begin
    res_n                    = res_q;
    res_n[cnt*CHUNK +: CHUNK] = csum;
  end

`ifdef SATURATE_EN
  // On overflow the true sign is the sign of the latched a.
  always_comb begin
    res_fin = res_n;
    if (ovf_n)
      res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign res_fin = res_n;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = BUSY;
      BUSY:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (in_valid) begin
          a_q  <= a;
          b_q  <= b ^ {WIDTH{op}};
          c_q  <= op;
          op_q <= op_e'(op);
          cnt  <= '0;
        end
        BUSY: begin
          c_q <= cout;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            res_q   <= res_fin;
            carry_q <= cout ^ (op_q == OP_SUB);
            ovf_q   <= ovf_n;
            zero_q  <= (res_fin == '0);
          end else begin
            res_q <= res_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_unit.sv
// Directed bench for addsub_unit: 32/8 main instance plus 32/32 and 16/4 regressions.
module tb_addsub_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a32 = '0, b32 = '0;
  logic [15:0] a16 = '0, b16 = '0;

  logic        in_ready_m, out_valid_m, carry_m, overflow_m, zero_m;
  logic [31:0] result_m;
  logic        in_ready_s, out_valid_s, carry_s, overflow_s, zero_s;
  logic [31:0] result_s;
  logic        in_ready_h, out_valid_h, carry_h, overflow_h, zero_h;
  logic [15:0] result_h;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_s;
  logic [2:0]  capf_s;
  int          ncap_s = 0;
  logic [15:0] cap_h;
  logic [2:0]  capf_h;
  int          ncap_h = 0;

`ifdef SATURATE_EN
  localparam logic [31:0] E3  = 32'h8000_0000;
  localparam logic [31:0] E4  = 32'h7FFF_FFFF;
  localparam logic [15:0] E3H = 16'h8000;
  localparam logic [15:0] E4H = 16'h7FFF;
`else
  localparam logic [31:0] E3  = 32'h7FFF_FFFF;
  localparam logic [31:0] E4  = 32'h8000_0000;
  localparam logic [15:0] E3H = 16'h7FFF;
  localparam logic [15:0] E4H = 16'h8000;
`endif

  always #5 clk = ~clk;

  addsub_unit #(.WIDTH(32), .CHUNK(8)) u_main (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m), .op(op),
    .a(a32), .b(b32), .out_valid(out_valid_m), .out_ready(out_ready),
    .result(result_m), .carry(carry_m), .overflow(overflow_m), .zero(zero_m)
  );

  addsub_unit #(.WIDTH(32), .CHUNK(32)) u_single (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .op(op),
    .a(a32), .b(b32), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .carry(carry_s), .overflow(overflow_s), .zero(zero_s)
  );

  addsub_unit #(.WIDTH(16), .CHUNK(4)) u_half (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_h), .op(op),
    .a(a16), .b(b16), .out_valid(out_valid_h), .out_ready(out_ready),
    .result(result_h), .carry(carry_h), .overflow(overflow_h), .zero(zero_h)
  );

  // Snapshot the secondary instances whenever they present a result.
  always @(negedge clk) begin
    if (out_valid_s) begin
      cap_s  <= result_s;
      capf_s <= {carry_s, overflow_s, zero_s};
      ncap_s <= ncap_s + 1;
    end
    if (out_valid_h) begin
      cap_h  <= result_h;
      capf_h <= {carry_h, overflow_h, zero_h};
      ncap_h <= ncap_h + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // flags are {carry, overflow, zero}
  task automatic run_vec(input string tag, input logic opv,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] er, input logic [2:0] ef,
                         input logic [15:0] ah, input logic [15:0] bh,
                         input logic [15:0] erh, input logic [2:0] efh);
    int n, cs0, ch0;
    cs0 = ncap_s;
    ch0 = ncap_h;
    chk({tag, ".idle_rdy"}, {31'b0, in_ready_m}, 32'd1);
    in_valid = 1'b1; op = opv; a32 = av; b32 = bv; a16 = ah; b16 = bh;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".busy_rdy"}, {31'b0, in_ready_m}, 32'd0);
    n = 0;
    while (!out_valid_m && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, n, 32'd4);
    chk({tag, ".result"}, result_m, er);
    chk({tag, ".flags"}, {29'b0, carry_m, overflow_m, zero_m}, {29'b0, ef});
    @(posedge clk); #1;
    chk({tag, ".back_idle"}, {30'b0, in_ready_m, out_valid_m}, 32'b10);
    chk({tag, ".s_seen"}, {31'b0, ncap_s != cs0}, 32'd1);
    chk({tag, ".s_result"}, cap_s, er);
    chk({tag, ".s_flags"}, {29'b0, capf_s}, {29'b0, ef});
    chk({tag, ".h_seen"}, {31'b0, ncap_h != ch0}, 32'd1);
    chk({tag, ".h_result"}, {16'b0, cap_h}, {16'b0, erh});
    chk({tag, ".h_flags"}, {29'b0, capf_h}, {29'b0, efh});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // reset with a simultaneous in_valid: nothing may be latched
    in_valid = 1'b1; a32 = 32'h1234; b32 = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    chk("rst.in_ready", {31'b0, in_ready_m}, 32'd1);
    chk("rst.out_valid", {31'b0, out_valid_m}, 32'd0);
    chk("rst.result", result_m, 32'd0);
    chk("rst.flags", {29'b0, carry_m, overflow_m, zero_m}, 32'd0);
    @(posedge clk); #1;
    chk("rst.still_idle", {30'b0, in_ready_m, out_valid_m}, 32'b10);

    run_vec("t1_add_wrap", 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 3'b101,
            16'h0001, 16'hFFFF, 16'h0, 3'b101);
    run_vec("t2_sub_borrow", 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 3'b100,
            16'd5, 16'd7, 16'hFFFE, 3'b100);
    run_vec("t3_sub_ovf", 1'b1, 32'h8000_0000, 32'd1, E3, 3'b010,
            16'h8000, 16'd1, E3H, 3'b010);
    run_vec("t4_add_ovf", 1'b0, 32'h7FFF_FFFF, 32'd1, E4, 3'b010,
            16'h7FFF, 16'd1, E4H, 3'b010);

    // t5: hold the result in DONE while stray in_valid pulses arrive
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; a32 = 32'd3; b32 = 32'd4; a16 = 16'd3; b16 = 16'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("t5.done", {31'b0, out_valid_m}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a32 = 32'd100 + i; b32 = 32'd1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("t5.hold_result", result_m, 32'd7);
      chk("t5.hold_flags", {29'b0, carry_m, overflow_m, zero_m}, 32'd0);
      chk("t5.hold_vr", {30'b0, in_ready_m, out_valid_m}, 32'b01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5.released", {30'b0, in_ready_m, out_valid_m}, 32'b10);
    repeat (6) @(posedge clk);
    #1;
    chk("t5.no_ghost", {30'b0, in_ready_m, out_valid_m}, 32'b10);

    // t6: reset during the second BUSY cycle aborts the operation
    in_valid = 1'b1; op = 1'b1; a32 = 32'd100; b32 = 32'd1; a16 = 16'd100; b16 = 16'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6.in_ready", {31'b0, in_ready_m}, 32'd1);
    chk("t6.out_valid", {31'b0, out_valid_m}, 32'd0);
    chk("t6.result", result_m, 32'd0);
    chk("t6.flags", {29'b0, carry_m, overflow_m, zero_m}, 32'd0);
    run_vec("t6_sub_after", 1'b1, 32'd10, 32'd3, 32'd7, 3'b000,
            16'd10, 16'd3, 16'd7, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
